// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg: shared vector-unit types, osize constants and reduction op/identity helpers
package riscv_v_pkg;
  localparam logic [1:0] OSIZE_8  = 2'd0;
  localparam logic [1:0] OSIZE_16 = 2'd1;
  localparam logic [1:0] OSIZE_32 = 2'd2;
  localparam logic [1:0] OSIZE_64 = 2'd3;
  typedef enum logic [2:0] {
    RED_SUM  = 3'd0,
    RED_MAXU = 3'd1,
    RED_MAX  = 3'd2,
    RED_MINU = 3'd3,
    RED_MIN  = 3'd4
  } reduct_op_e;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } reduct_state_e;
  function automatic logic [63:0] sew_mask(input logic [1:0] osize);
    return osize == OSIZE_8  ? 64'h0000_0000_0000_00ff :
           osize == OSIZE_16 ? 64'h0000_0000_0000_ffff :
           osize == OSIZE_32 ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
  endfunction
  function automatic logic [63:0] sew_sext(input logic [63:0] v, input logic [1:0] osize);
    return osize == OSIZE_8  ? {{56{v[7]}}, v[7:0]} :
           osize == OSIZE_16 ? {{48{v[15]}}, v[15:0]} :
           osize == OSIZE_32 ? {{32{v[31]}}, v[31:0]} : v;
  endfunction
  function automatic logic [63:0] reduct_identity(input reduct_op_e op, input logic [1:0] osize);
    logic [63:0] m;
    m = sew_mask(osize);
    return op == RED_MAX  ? m ^ (m >> 1) :
           op == RED_MINU ? m :
           op == RED_MIN  ? m >> 1 : 64'd0;
  endfunction
  // Operands are masked to SEW first, so bits above SEW never leak into the result
  function automatic logic [63:0] reduct_combine(input reduct_op_e op, input logic [1:0] osize,
                                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, am, bm, r;
    logic gtu, gts;
    m   = sew_mask(osize);
    am  = a & m;
    bm  = b & m;
    gtu = am > bm;
    gts = $signed(sew_sext(am, osize)) > $signed(sew_sext(bm, osize));
    case (op)
      RED_MAXU: r = gtu ? am : bm;
      RED_MAX:  r = gts ? am : bm;
      RED_MINU: r = gtu ? bm : am;
      RED_MIN:  r = gts ? bm : am;
      default:  r = (am + bm) & m;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/riscv_v_reduct_tree.sv
// riscv_v_reduct_tree: osize-aware pairwise reduction of one beat to one element
module riscv_v_reduct_tree
  import riscv_v_pkg::*;
#(
  parameter int DATA_BYTES = 16
) (
  input  reduct_op_e              op,
  input  logic [1:0]              osize,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   byte_valid,
  output logic [63:0]             result
);
  logic [63:0] red [4];
  // One heap-ordered tree per element size; osize picks the root
  for (genvar s = 0; s < 4; s++) begin : g_sz
    localparam int E = 1 << s;
    localparam int N = DATA_BYTES / E;
    logic [63:0] node [2*N-1];
    for (genvar i = 0; i < N; i++) begin : g_leaf
      assign node[N-1+i] = &byte_valid[i*E +: E] ? 64'(data[i*E*8 +: E*8])
                                                 : reduct_identity(op, 2'(s));
    end
    for (genvar i = 0; i < N-1; i++) begin : g_node
      assign node[i] = reduct_combine(op, 2'(s), node[2*i+1], node[2*i+2]);
    end
    assign red[s] = node[0];
  end
  assign result = red[osize];
endmodule

// File: rtl/riscv_v_reduct_accum.sv
// riscv_v_reduct_accum: multi-beat vector reduction with scalar accumulator and valid/ready result
module riscv_v_reduct_accum
  import riscv_v_pkg::*;
#(
  parameter int DATA_BYTES     = 16,
  parameter int MAX_ELEM_BYTES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [2:0]                  in_op,
  input  logic [1:0]                  in_osize,
  input  logic [8*MAX_ELEM_BYTES-1:0] in_seed,
  input  logic [8*DATA_BYTES-1:0]     in_data,
  input  logic [DATA_BYTES-1:0]       in_byte_valid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [8*MAX_ELEM_BYTES-1:0] out_result,
  output logic                        proto_err
);
  reduct_state_e state, state_d;
  reduct_op_e op_q, op_eff;
  logic [1:0] osize_q, osize_eff;
  logic [63:0] acc, tree_res, fold;
  logic accept, load, violation;
  assign accept    = in_valid & in_ready;
  assign op_eff    = in_first ? (in_op > 3'd4 ? RED_SUM : reduct_op_e'(in_op)) : op_q;
  assign osize_eff = in_first ? in_osize : osize_q;
  assign load      = accept & ~flush & (in_first | state == ACCUM);
  assign violation = accept & ~flush & (state == IDLE ? ~in_first : state == ACCUM & in_first);
  riscv_v_reduct_tree #(.DATA_BYTES(DATA_BYTES)) u_tree (
    .op         (op_eff),
    .osize      (osize_eff),
    .data       (in_data),
    .byte_valid (in_byte_valid),
    .result     (tree_res)
  );
  // A first beat always reseeds, which also covers the restart-from-ACCUM case
  assign fold = reduct_combine(op_eff, osize_eff, in_first ? 64'(in_seed) : acc, tree_res);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end
  always_comb begin
    state_d = flush ? IDLE :
              state == RESULT ? (out_ready ? IDLE : RESULT) :
              load ? (in_last ? RESULT : ACCUM) : state;
  end
  always_comb begin
    in_ready   = state != RESULT;
    out_valid  = state == RESULT;
    out_result = out_valid ? acc[8*MAX_ELEM_BYTES-1:0] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      op_q      <= RED_SUM;
      osize_q   <= OSIZE_8;
      proto_err <= 1'b0;
    end else begin
      proto_err <= violation;
      if (load) begin
        acc     <= fold;
        op_q    <= op_eff;
        osize_q <= osize_eff;
      end
    end
  end
endmodule

// File: tb/tb_riscv_v_reduct_accum.sv
// tb_riscv_v_reduct_accum: directed scoreboard bench for the vector reduction accumulator
module tb_riscv_v_reduct_accum;
  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, in_first, in_last;
  logic [2:0]   in_op;
  logic [1:0]   in_osize;
  logic [63:0]  in_seed;
  logic [127:0] in_data;
  logic [15:0]  in_byte_valid;
  logic         out_valid, out_ready, proto_err;
  logic [63:0]  out_result;
  logic [63:0]  exp_q [$];
  int compared = 0;
  int mismatched = 0;

  riscv_v_reduct_accum dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_op(in_op), .in_osize(in_osize),
    .in_seed(in_seed), .in_data(in_data), .in_byte_valid(in_byte_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic f, input logic l, input logic [2:0] op, input logic [1:0] os,
                       input logic [63:0] seed, input logic [127:0] d, input logic [15:0] bv);
    in_valid = 1'b1; in_first = f; in_last = l; in_op = op; in_osize = os;
    in_seed = seed; in_data = d; in_byte_valid = bv;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int budget);
    int n;
    logic [63:0] e;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 64'hdead_beef_dead_beef;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check(tag, out_result, e);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [127:0] d;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_op = '0; in_osize = '0; in_seed = '0; in_data = '0; in_byte_valid = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: SUM 8b, bytes 1..16 + seed 10 = 146, valid on the very next cycle for one cycle
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i + 1);
    exp_q.push_back(64'h92);
    drive(1, 1, 3'd0, 2'd0, 64'd10, d, 16'hffff);
    expect_out("t1_sum8", 1);
    @(negedge clk);
    check("t1_one_cycle", 64'(out_valid), 64'd0);

    // 2: MAX vs MAXU over two 16b beats
    exp_q.push_back(64'h7fff);
    drive(1, 0, 3'd2, 2'd1, 64'd0, 128'h7fff_8000, 16'h000f);
    drive(0, 1, 3'd0, 2'd0, 64'd0, 128'h0001, 16'h0003);
    expect_out("t2_max16", 4);
    exp_q.push_back(64'h8000);
    drive(1, 0, 3'd1, 2'd1, 64'd0, 128'h7fff_8000, 16'h000f);
    drive(0, 1, 3'd0, 2'd0, 64'd0, 128'h0001, 16'h0003);
    expect_out("t2_maxu16", 4);

    // 3: MIN 32b, cleared zero element and half-masked 0x80000000 are ignored
    exp_q.push_back(64'hffff_fffd);
    drive(1, 1, 3'd4, 2'd2, 64'd100, {32'h8000_0000, 32'h0, 32'hffff_fffd, 32'h5}, 16'h30ff);
    expect_out("t3_min32", 4);

    // 4: SUM 64b wrap, then an all-inactive beat returns the seed
    exp_q.push_back(64'h0);
    drive(1, 1, 3'd0, 2'd3, 64'hffff_ffff_ffff_ffff, {64'hdead, 64'h1}, 16'h00ff);
    expect_out("t4_wrap64", 4);
    exp_q.push_back(64'hffff_ffff_ffff_ffff);
    drive(1, 1, 3'd0, 2'd3, 64'hffff_ffff_ffff_ffff, {64'hdead, 64'h1}, 16'h0000);
    expect_out("t4_empty64", 4);

    // 5: backpressure holds the result, then a new reduction right after the handshake
    out_ready = 1'b0;
    exp_q.push_back(64'h20);
    drive(1, 1, 3'd0, 2'd0, 64'd0, {16{8'h02}}, 16'hffff);
    expect_out("t5_held", 2);
    for (int k = 0; k < 3; k++) begin
      check("t5_hold_valid", 64'(out_valid), 64'd1);
      check("t5_hold_result", out_result, 64'h20);
      check("t5_hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(64'h0808);
    drive(1, 1, 3'd0, 2'd1, 64'd0, {8{16'h0101}}, 16'hffff);
    expect_out("t5_next", 1);

    // 6a: non-first beat in IDLE
    drive(0, 1, 3'd0, 2'd0, 64'd0, {16{8'h01}}, 16'hffff);
    @(negedge clk);
    check("t6a_proto_err", 64'(proto_err), 64'd1);
    check("t6a_no_out", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t6a_pulse_end", 64'(proto_err), 64'd0);
    check("t6a_still_no_out", 64'(out_valid), 64'd0);

    // 6b: in_first during ACCUM restarts; only the second reduction reports
    exp_q.push_back(64'h20);
    drive(1, 0, 3'd0, 2'd0, 64'd1, {16{8'h01}}, 16'hffff);
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i);
    drive(1, 0, 3'd1, 2'd0, 64'd3, d, 16'hffff);
    @(negedge clk);
    check("t6b_proto_err", 64'(proto_err), 64'd1);
    check("t6b_no_out", 64'(out_valid), 64'd0);
    drive(0, 1, 3'd0, 2'd0, 64'd0, 128'h20, 16'h0001);
    expect_out("t6b_restart", 4);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t6b_single_out", 64'(out_valid), 64'd0);
    end

    // 6c: flush in ACCUM wins over a concurrent last beat
    drive(1, 0, 3'd0, 2'd0, 64'd0, {16{8'h01}}, 16'hffff);
    flush = 1'b1;
    drive(0, 1, 3'd0, 2'd0, 64'd0, {16{8'h01}}, 16'hffff);
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6c_flush_no_out", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    drive(0, 1, 3'd0, 2'd0, 64'd0, {16{8'h01}}, 16'hffff);
    @(negedge clk);
    check("t6c_idle_after_flush", 64'(proto_err), 64'd1);

    // 6c': flush while holding a result drops out_valid
    out_ready = 1'b0;
    exp_q.push_back(64'h10);
    drive(1, 1, 3'd0, 2'd0, 64'd0, {16{8'h01}}, 16'hffff);
    expect_out("t6c_pre_flush", 4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t6c_result_flushed", 64'(out_valid), 64'd0);

    // 6d: async reset while in RESULT
    exp_q.push_back(64'h10);
    drive(1, 1, 3'd0, 2'd0, 64'd0, {16{8'h01}}, 16'hffff);
    expect_out("t6d_pre_reset", 4);
    #2 rst_n = 1'b0;
    #1;
    check("t6d_valid_drop", 64'(out_valid), 64'd0);
    check("t6d_result_zero", out_result, 64'd0);
    check("t6d_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // reserved op encoding behaves as SUM
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i + 1);
    exp_q.push_back(64'h88);
    drive(1, 1, 3'd7, 2'd0, 64'd0, d, 16'hffff);
    expect_out("t7_reserved_op", 1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/riscv_v_reduct_accum.md
Name: riscv_v_reduct_accum

Overview:
- Multi-beat vector reduction unit for vredsum/vredmax/vredmaxu/vredmin/vredminu.
- Consumes a register group of any length as a stream of DATA_BYTES-wide beats and reduces each beat to one element with a combinational tree.
- Folds that element into a scalar accumulator seeded from vs1[0], then returns the scalar on a valid/ready output.
- Sits beside the vector ALU adder in the execute stage. It handles LMUL>1 and cross-beat reductions, which the single-beat adder cannot.

Parameters:
- DATA_BYTES, 16 (RISCV_V_NUM_BYTES_DATA): bytes per beat; power of two, >= MAX_ELEM_BYTES.
- MAX_ELEM_BYTES, 8: widest element (SEW=64); sets seed and result width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the reduction in progress
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_first  in  1  first beat of a reduction; op, osize and seed are sampled only on this beat
- in_last  in  1  final beat of the reduction
- in_op  in  3  0=SUM 1=MAXU 2=MAX 3=MINU 4=MIN; 5-7 reserved, treated as SUM
- in_osize  in  2  0=8b 1=16b 2=32b 3=64b
- in_seed  in  8*MAX_ELEM_BYTES  scalar seed (vs1[0]), low osize bits used
- in_data  in  8*DATA_BYTES  beat data, element i in bytes [i*E +: E]
- in_byte_valid  in  DATA_BYTES  per-byte active mask
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_result  out  8*MAX_ELEM_BYTES  reduction result, zero-extended above osize
- proto_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, out_result=0, proto_err=0, in_ready=1, accumulator=0.
- The clock and reset are fixed as decided: one clock, reset asynchronous and active-low.
- FSM states:
  - IDLE: in_ready=1.
  - ACCUM: in_ready=1.
  - RESULT: in_ready=0, out_valid=1.
- IDLE, accepted beat with in_first: op/osize latched; acc = op(seed, tree(beat)). Next state is RESULT if in_last, else ACCUM.
- IDLE, accepted beat without in_first: beat dropped, proto_err pulses, state stays IDLE.
- ACCUM, accepted beat without in_first: acc = op(acc, tree(beat)); in_op/in_osize/in_seed are ignored. Goes to RESULT on in_last.
- ACCUM, accepted beat with in_first: the previous reduction is discarded and produces no output. A restart happens with the new seed/op, and proto_err pulses.
- RESULT: out_result = acc; it goes back to IDLE on out_valid & out_ready. out_result holds stable while out_ready=0.
- Latency: the last beat is accepted at edge T; out_valid=1 from T+1. The next first beat can be accepted in the cycle after the output handshake, which gives 1 idle cycle between reductions.
- Element activity: an element is active only when all of its byte_valid bits are 1. Any partially or fully cleared element contributes the identity value.
- Identity values: SUM 0; MAXU 0; MAX 1<<(SEW-1); MINU all-ones; MIN (1<<(SEW-1))-1.
- A beat with no active elements leaves acc unchanged.
- Arithmetic is done in the latched SEW only:
  - SUM wraps modulo 2^SEW.
  - MAX/MIN compare as two's complement; MAXU/MINU compare unsigned.
  - Bits above SEW in acc and out_result are always 0.
- Tree: log2(DATA_BYTES/E) levels, E = 2^osize bytes, combinational within the accept cycle.
- flush takes priority over every other event. The next state is IDLE, out_valid drops the next cycle and any in-flight beat is ignored. flush in IDLE is a no-op.
- Asserting rst_n mid-reduction returns everything to reset values immediately, with no output.

Decomposition:
- Shared package riscv_v_pkg receives:
  - the reduct_op_e enum (SUM/MAXU/MAX/MINU/MIN);
  - the reduct_state_e enum (IDLE/ACCUM/RESULT);
  - the identity-value function keyed by op and osize.
- The osize encoding reuses the existing osize constants.
- One sub-module, riscv_v_reduct_tree: a combinational, osize-aware pairwise reduce from one beat to one element.
- The same op/identity cell is reused for the final fold with acc.

Test Plan (DATA_BYTES=16):
1. SUM, 8b, one beat, first&last, bytes 1..16 all valid, seed 10 -> out_result=0x92 (146) at T+1, out_valid one cycle.
2. MAX vs MAXU, 16b, two beats containing 0x8000, 0x7FFF, 0x0001, seed 0 -> MAX gives 0x7FFF; MAXU gives 0x8000.
3. MIN, 32b, elements {5, 0xFFFFFFFD, 0}, where 0 has its byte_valid cleared and one element is half-masked -> 0xFFFFFFFD; the half-masked element is ignored.
4. SUM, 64b, seed all-ones plus element 1 -> 0, wrap with no error. The same test with every byte_valid=0 -> result equals the seed.
5. Backpressure: out_ready=0 for 3 cycles -> out_valid and out_result stable, in_ready=0. A new first beat is accepted the cycle after the handshake.
6. Protocol checks:
   - a non-first beat in IDLE -> proto_err pulse and no output;
   - in_first during ACCUM -> restart, and only the second reduction result appears;
   - flush in ACCUM -> IDLE with no output;
   - rst_n low mid-RESULT -> out_valid=0 immediately.
